// File: rtl/param_updown_counter.sv
// Parametrised up/down event/timer counter with a prescaler and wrap, saturate and one-shot modes.
// All outputs are registered except terminal, and every update happens on the edge of its tick cycle.
module param_updown_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic [1:0]            mode,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count_out,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  terminal,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  busy_q, busy_d;
  logic                  tick;
  logic                  one_shot;
  logic                  saturate;
  logic                  at_top;
  logic                  at_zero;

  assign one_shot = (mode == 2'b10);
  assign saturate = (mode == 2'b01);
  assign at_top   = (cnt_q >= limit);
  assign at_zero  = (cnt_q == '0);

  // A prescaler left above a newly lowered setting drops back to 0 without firing.
  always_comb begin
    tick  = 1'b0;
    psc_d = psc_q;
    if (clear || load) begin
      psc_d = '0;
    end else if (enable) begin
      if (psc_q == prescale) begin
        tick  = 1'b1;
        psc_d = '0;
      end else if (psc_q > prescale) begin
        psc_d = '0;
      end else begin
        psc_d = psc_q + PRESCALE_W'(1);
      end
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    state_d = one_shot ? state_q : IDLE;
    if (clear) begin
      cnt_d   = '0;
      state_d = IDLE;
    end else if (load) begin
      cnt_d   = load_value;
      state_d = one_shot ? RUN : IDLE;
    end else if (tick) begin
      if (one_shot) begin
        if (state_q == RUN) begin
          if (up_down) begin
            if (at_top || (cnt_q + WIDTH'(1) == limit)) begin
              cnt_d   = limit;
              ovf_d   = 1'b1;
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + WIDTH'(1);
            end
          end else begin
            if (at_zero || (cnt_q == WIDTH'(1))) begin
              cnt_d   = '0;
              unf_d   = 1'b1;
              state_d = DONE;
            end else begin
              cnt_d = cnt_q - WIDTH'(1);
            end
          end
        end
      end else if (up_down) begin
        if (at_top) begin
          cnt_d = saturate ? limit : '0;
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          cnt_d = saturate ? '0 : limit;
          unf_d = 1'b1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      psc_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      psc_q   <= psc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      busy_q  <= busy_d;
    end
  end

  assign count_out = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign busy      = busy_q;
  assign terminal  = up_down ? (cnt_q == limit) : at_zero;

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised successor to the team's fixed 8-bit free-running counter.
- Configurable width and prescaler; runtime direction, modulo limit, parallel load, synchronous clear.
- Three count modes: wrap, saturate, one-shot.
- Serves as the general event/timer counter for datapath and control blocks. Single-cycle next-state logic, no internal pipelining; all outputs except `terminal` are registered.

Parameters:
- WIDTH, 8, counter width in bits (≥2).
- PRESCALE_W, 4, prescaler divider width; tick every prescale+1 enabled cycles.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  count enable; also gates the prescaler.
- up_down  in  1  direction: 1=up, 0=down.
- mode  in  2  count mode: 00=wrap, 01=saturate, 10=one-shot, 11=reserved, treated as wrap.
- clear  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load; in one-shot mode also starts a run.
- load_value  in  WIDTH  value taken on load.
- limit  in  WIDTH  upper terminal value; count range 0..limit.
- prescale  in  PRESCALE_W  divider setting; 0 = tick every enabled cycle.
- count_out  out  WIDTH  registered count.
- overflow  out  1  one-cycle registered pulse on an up-terminal event.
- underflow  out  1  one-cycle registered pulse on a down-terminal event.
- terminal  out  1  combinational level: (up_down ? count_out==limit : count_out==0).
- busy  out  1  registered; 1 while a one-shot run is active.

Behaviour:
- Reset (async assert, sync release): count_out=0, overflow=0, underflow=0, busy=0, prescaler=0, FSM=IDLE.
- Priority per cycle: clear > load > tick > hold.
- clear: count=0, prescaler=0, FSM=IDLE, busy=0, flags=0.
- load: count=load_value, prescaler=0, flags=0.
  - mode=10: FSM→RUN, busy=1.
  - Other modes: FSM stays IDLE.
- Prescaler and tick:
  - Prescaler increments on enabled cycles only.
  - tick = enable && prescaler==prescale; prescaler returns to 0 on tick.
  - Prescaler holds when enable=0.
  - A change of prescale while prescaler>prescale: prescaler returns to 0 on the next enabled cycle with no tick.
- Latency: count_out and flags update on the clock edge of the tick cycle, i.e. visible one cycle after tick.
- Wrap mode:
  - Up tick: count≥limit → count=0, overflow=1; else count+1.
  - Down tick: count==0 → count=limit, underflow=1; else count-1.
- Saturate mode:
  - Up tick at count≥limit: count=limit, overflow=1 (pulses on every such tick).
  - Down tick at 0: count holds 0, underflow=1.
  - Otherwise as wrap.
- One-shot mode, FSM states IDLE/RUN/DONE:
  - IDLE: count holds; ticks ignored.
  - RUN: counts per direction. The tick that lands count on limit (up) or 0 (down) → DONE, busy=0, overflow/underflow=1 for one cycle.
  - RUN with count already ≥limit (up) or 0 (down) at a tick → immediately DONE with a flag pulse; count forced to limit (up) or held at 0 (down).
  - DONE: count holds; ticks ignored, no further flags. load → RUN; clear → IDLE.
- Mode change:
  - Leaving mode 10 while RUN/DONE: FSM→IDLE, busy=0 next cycle.
  - Entering mode 10 while counting: FSM stays IDLE until load.
- Direction change takes effect on the next tick; no glitch on flags.
- Arithmetic is modulo 2^WIDTH internally, but the limit comparison always precedes increment, so count never exceeds max(limit, last loaded value).
- load_value > limit: loaded as-is.
  - Up: next tick wraps to 0 with overflow (wrap) or saturates to limit (saturate).
  - Down: decrements normally.
- limit=0: up tick always yields count=0 with overflow; down tick at 0 yields count=0 with underflow.
- Flags are 0 in every cycle without a qualifying tick; overflow and underflow are never both 1.
- Reset asserted mid-run: all state returns to reset values immediately, regardless of clk.

Test Plan:
1. Wrap up: WIDTH=8, limit=5, prescale=0, enable=1, up → count 0,1,2,3,4,5,0; overflow=1 only in the cycle count shows 0 after 5; terminal=1 while count=5.
2. Prescaled down wrap: prescale=2, limit=3, load_value=1, then down → count changes every 3rd enabled cycle: 1,0,3; underflow=1 exactly once at the 0→3 step; enable low for 4 cycles mid-sequence freezes both count and prescaler.
3. Saturate: mode=01, limit=200, load_value=198, up, prescale=0 → 199,200,200,200; overflow=1 on the 2nd and 3rd ticks at 200; switch to down → 199.
4. One-shot: mode=10, load_value=10, down, prescale=0 → busy=1; count 9..0; at 0 busy=0, underflow one pulse; 5 further ticks → count stays 0, no flags; reload 3 → busy=1, counts 2,1,0.
5. Priority and boundary: same cycle clear=1, load=1, tick → count=0, busy=0. load_value=250 with limit=100, up, wrap → next tick count=0 with overflow.
6. Async reset: assert reset between clock edges during a one-shot RUN at count=7 → count_out=0, busy=0, flags=0 before the next edge; after release, no ticks until load in mode 10.
